// File: rtl/conv_out_collector.sv
// conv_out_collector: gathers a convolution PE's raster-ordered results.
// Row-wrap garbage positions are discarded. Kept results are saturated to
// OUT_W bits and queued in a small FIFO for a ready-gated consumer.
// Optional build macro: CONV_OUT_RELU_EN forces negative kept values to zero
// before saturation. Without it the sign of each kept value is preserved.
module conv_out_collector #(
  parameter int KERNEL_SIZE = 3,
  parameter int FM_SIZE     = 8,
  parameter int OUT_W       = 16,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_en,
  input  logic signed [47:0]            i_P,
  input  logic                          i_ready,
  output logic signed [OUT_W-1:0]       o_data,
  output logic                          o_valid,
  output logic                          o_frame_done,
  output logic                          o_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_count
);

  localparam int OUT_SIDE = FM_SIZE - KERNEL_SIZE + 1;
  localparam int COL_W    = $clog2(FM_SIZE + 1);
  localparam int ROW_W    = $clog2(OUT_SIDE + 1);
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;

  localparam logic [COL_W-1:0] COL_LAST     = COL_W'(FM_SIZE - 1);
  localparam logic [COL_W-1:0] COL_KEEP_MAX = COL_W'(FM_SIZE - KERNEL_SIZE);
  localparam logic [ROW_W-1:0] ROW_LAST     = ROW_W'(OUT_SIDE - 1);
  localparam logic [CNT_W-1:0] FULL_CNT     = CNT_W'(FIFO_DEPTH);

  localparam logic signed [47:0] SAT_MAX = {{(48-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [47:0] SAT_MIN = {{(48-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DONE
  } state_t;

  // Optional rectification applied ahead of the clamp.
  function automatic logic signed [47:0] rectify(input logic signed [47:0] x);
`ifdef CONV_OUT_RELU_EN
    return x[47] ? 48'sd0 : x;
`else
    return x;
`endif
  endfunction

  // Clamp a 48-bit signed accumulator value into OUT_W signed bits.
  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [47:0] x);
    logic signed [OUT_W-1:0] r;
    if (x > SAT_MAX)      r = SAT_MAX[OUT_W-1:0];
    else if (x < SAT_MIN) r = SAT_MIN[OUT_W-1:0];
    else                  r = x[OUT_W-1:0];
    return r;
  endfunction

  state_t             state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic               frame_done_q, frame_done_d;
  logic               overflow_q, overflow_d;

  logic                    vld_p0_q;
  logic signed [OUT_W-1:0] data_p0_q;

  logic signed [OUT_W-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;

  logic process_pos;
  logic start_frame;
  logic last_pos;
  logic keep_pos;
  logic push;
  logic pop;
  logic full;
  logic push_ok;

  assign last_pos = (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign keep_pos = process_pos && (col_q <= COL_KEEP_MAX);

  // Frame FSM: walk the raster position counters and decide which samples count.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    process_pos  = 1'b0;
    start_frame  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_en) begin
          start_frame = 1'b1;
          process_pos = 1'b1;
        end
      end
      S_COLLECT: begin
        if (i_en) begin
          process_pos = 1'b1;
        end else begin
          state_d = S_IDLE;
          col_d   = '0;
          row_d   = '0;
        end
      end
      S_DONE: begin
        if (!i_en) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        col_d   = '0;
        row_d   = '0;
      end
    endcase
    if (process_pos) begin
      if (last_pos) begin
        state_d = S_DONE;
        col_d   = '0;
        row_d   = '0;
      end else begin
        state_d = S_COLLECT;
        if (col_q == COL_LAST) begin
          col_d = '0;
          row_d = row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
    end
    frame_done_d = process_pos && last_pos;
  end

  // FSM state, position counters and frame-done pulse register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Stage p0 control: a kept sample is in flight toward the FIFO.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) vld_p0_q <= 1'b0;
    else          vld_p0_q <= keep_pos;
  end

  // Stage p0 data: rectified and saturated sample, loaded only when kept.
  always_ff @(posedge i_clk) begin
    if (keep_pos) data_p0_q <= saturate(rectify(i_P));
  end

  assign push    = vld_p0_q;
  assign pop     = (count_q != '0) && i_ready;
  assign full    = (count_q == FULL_CNT);
  assign push_ok = push && (!full || pop);

  // FIFO pointer, occupancy and sticky overflow next-state.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (start_frame)         overflow_d = 1'b0;
    if (push && full && !pop) overflow_d = 1'b1;
  end

  // FIFO control registers; stored words are deliberately left unreset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage write; a write to the head while full and popping is safe.
  always_ff @(posedge i_clk) begin
    if (push_ok) fifo_mem_q[wr_ptr_q] <= data_p0_q;
  end

  assign o_valid      = (count_q != '0);
  assign o_data       = o_valid ? fifo_mem_q[rd_ptr_q] : '0;
  assign o_frame_done = frame_done_q;
  assign o_overflow   = overflow_q;
  assign o_count      = count_q;

endmodule

// File: tb/tb_conv_out_collector.sv
// Directed bench for conv_out_collector. Instance A uses a 4x4 map with a
// 3x3 kernel; instance B uses an 8x8 map so one row holds six kept samples.
module tb_conv_out_collector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic                a_en, a_ready;
  logic signed [47:0]  a_P;
  logic signed [15:0]  a_data;
  logic                a_valid, a_done, a_ovf;
  logic [2:0]          a_count;

  logic                b_en, b_ready;
  logic signed [47:0]  b_P;
  logic signed [15:0]  b_data;
  logic                b_valid, b_done, b_ovf;
  logic [2:0]          b_count;

  conv_out_collector #(
    .KERNEL_SIZE(3), .FM_SIZE(4), .OUT_W(16), .FIFO_DEPTH(4)
  ) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(a_en), .i_P(a_P), .i_ready(a_ready),
    .o_data(a_data), .o_valid(a_valid), .o_frame_done(a_done),
    .o_overflow(a_ovf), .o_count(a_count)
  );

  conv_out_collector #(
    .KERNEL_SIZE(3), .FM_SIZE(8), .OUT_W(16), .FIFO_DEPTH(4)
  ) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(b_en), .i_P(b_P), .i_ready(b_ready),
    .o_data(b_data), .o_valid(b_valid), .o_frame_done(b_done),
    .o_overflow(b_ovf), .o_count(b_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cap_a[$];
  int cap_b[$];
  int exp_q[$];
  int done_cnt_a = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_q(input string tag, input int got[$], input int exp[$]);
    check({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      check($sformatf("%s[%0d]", tag, i), (i < got.size()) ? got[i] : -999999, exp[i]);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Record every popped word and every frame-done pulse, away from the edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_valid && a_ready) cap_a.push_back(int'(a_data));
      if (b_valid && b_ready) cap_b.push_back(int'(b_data));
      if (a_done) done_cnt_a++;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  int sv[8];

  initial begin
    rst_n = 1'b1;
    a_en = 1'b0; a_P = '0; a_ready = 1'b0;
    b_en = 1'b0; b_P = '0; b_ready = 1'b0;
    #2 rst_n = 1'b0;
    tick; tick;
    check("rst_valid", a_valid, 0);
    check("rst_data", a_data, 0);
    check("rst_done", a_done, 0);
    check("rst_ovf", a_ovf, 0);
    check("rst_count", a_count, 0);
    check("rst_count_b", b_count, 0);
    rst_n = 1'b1;
    tick;

    // Basic frame: 1..8 keeps 1,2,5,6
    a_ready = 1'b1; cap_a.delete(); done_cnt_a = 0;
    for (int i = 1; i <= 8; i++) begin
      a_en = 1'b1; a_P = 48'(i);
      tick;
      if (i == 7) check("doneA_early", a_done, 0);
      if (i == 8) check("doneA_pulse", a_done, 1);
    end
    a_en = 1'b0;
    tick;
    check("doneA_low", a_done, 0);
    repeat (4) tick;
    exp_q = {1, 2, 5, 6};
    check_q("frameA", cap_a, exp_q);
    check("doneA_cnt", done_cnt_a, 1);

    // Saturation
    cap_a.delete();
    sv = '{70000, -70000, 0, 0, 32768, -32768, 0, 0};
    for (int i = 0; i < 8; i++) begin
      a_en = 1'b1; a_P = 48'(sv[i]);
      tick;
    end
    a_en = 1'b0;
    repeat (4) tick;
`ifdef CONV_OUT_RELU_EN
    exp_q = {32767, 0, 32767, 0};
`else
    exp_q = {32767, -32768, 32767, -32768};
`endif
    check_q("sat", cap_a, exp_q);

    // Aborted frame then a full frame
    cap_a.delete(); done_cnt_a = 0;
    for (int i = 1; i <= 5; i++) begin
      a_en = 1'b1; a_P = 48'(i);
      tick;
    end
    a_en = 1'b0;
    repeat (3) tick;
    check("abort_nodone", done_cnt_a, 0);
    for (int i = 1; i <= 8; i++) begin
      a_en = 1'b1; a_P = 48'(i);
      tick;
    end
    a_en = 1'b0;
    repeat (4) tick;
    exp_q = {1, 2, 5, 1, 2, 5, 6};
    check_q("abort", cap_a, exp_q);
    check("abort_done_cnt", done_cnt_a, 1);

    // Reset mid-frame with three entries buffered
    a_ready = 1'b0; cap_a.delete();
    for (int i = 1; i <= 6; i++) begin
      a_en = 1'b1; a_P = 48'(i);
      tick;
    end
    check("pre_rst_count", a_count, 3);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", a_valid, 0);
    check("midrst_count", a_count, 0);
    check("midrst_data", a_data, 0);
    a_en = 1'b0;
    tick;
    rst_n = 1'b1;
    a_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      a_en = 1'b1; a_P = 48'(i);
      tick;
    end
    a_en = 1'b0;
    repeat (4) tick;
    exp_q = {1, 2, 5, 6};
    check_q("postrst", cap_a, exp_q);

    // Overflow on instance B: six kept samples into four entries
    b_ready = 1'b0; cap_b.delete();
    for (int i = 1; i <= 8; i++) begin
      b_en = 1'b1; b_P = 48'(i);
      tick;
    end
    b_en = 1'b0;
    repeat (3) tick;
    check("ovf_count", b_count, 4);
    check("ovf_flag", b_ovf, 1);
    b_ready = 1'b1;
    repeat (6) tick;
    exp_q = {1, 2, 3, 4};
    check_q("ovf_keep", cap_b, exp_q);
    check("ovf_sticky", b_ovf, 1);
    check("ovf_drained", b_count, 0);

    // New frame clears overflow; full FIFO with simultaneous pop and push
    b_ready = 1'b0; cap_b.delete();
    for (int i = 1; i <= 8; i++) begin
      b_en = 1'b1; b_P = 48'(10 + i);
      tick;
      if (i == 1) check("ovf_clear", b_ovf, 0);
      if (i == 5) begin
        check("full_count", b_count, 4);
        b_ready = 1'b1;
      end
      if (i == 6) begin
        check("poppush_count", b_count, 4);
        check("poppush_ovf", b_ovf, 0);
      end
    end
    b_en = 1'b0;
    repeat (6) tick;
    check("poppush_ovf_end", b_ovf, 0);
    exp_q = {11, 12, 13, 14, 15, 16};
    check_q("poppush", cap_b, exp_q);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
